// File: rtl/ascon_round_seq.sv
// Iterative round sequencer for the ASCON permutation: holds the 320-bit state,
// steps the round index for the external round datapath and hands back the result.
module ascon_round_seq #(
    parameter int P_A  = 12,
    parameter int P_B8 = 8,
    parameter int P_B6 = 6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [4:0][63:0] state_i,
    input  logic             abort_i,
    output logic [3:0]       round_o,
    output logic [4:0][63:0] state_o,
    input  logic [4:0][63:0] round_state_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0][63:0] out_state_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;

    fsm_t             fsm_q, fsm_d;
    logic [4:0][63:0] state_q, state_d;
    logic [3:0]       round_q, round_d;

    // The first index is chosen so that every permutation ends on index 11.
    function automatic logic [3:0] start_idx(input logic [1:0] mode);
        case (mode)
            2'b01:   start_idx = 4'(12 - P_B8);
            2'b10:   start_idx = 4'(12 - P_B6);
            default: start_idx = 4'(12 - P_A);
        endcase
    endfunction

    // Gated by resetb_i so no accept is advertised while reset is held.
    assign in_ready_o  = resetb_i && (fsm_q == IDLE) && !abort_i;
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q == RUN) || (fsm_q == DONE);
    assign round_o     = round_q;
    assign state_o     = state_q;
    assign out_state_o = state_q;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        if (abort_i) begin
            fsm_d   = IDLE;
            round_d = 4'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        state_d = state_i;
                        round_d = start_idx(mode_i);
                        fsm_d   = RUN;
                    end
                end
                RUN: begin
                    state_d = round_state_i;
                    if (round_q == LAST_ROUND) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_d   = IDLE;
                        round_d = 4'd0;
                    end
                end
                default: begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

endmodule
